// File: rtl/mux_arb_n.sv
// mux_arb_n: N-input, WIDTH-bit registered selector with valid/ready handshake.
// A channel is picked either by an explicit index (fixed mode) or by
// round-robin arbitration among valid channels. The chosen word is held in
// an output register that honours downstream backpressure.
module mux_arb_n #(
  parameter int WIDTH = 6,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    select,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_sel_r;
  logic             out_valid_r;
  logic [SELW-1:0]  rr_ptr_r;

  logic             load_en_s;
  logic             fix_hit_s;
  logic             hi_hit_s;
  logic [SELW-1:0]  hi_gnt_s;
  logic             lo_hit_s;
  logic [SELW-1:0]  lo_gnt_s;
  logic             gnt_hit_s;
  logic [SELW-1:0]  gnt_s;
  logic [SELW-1:0]  rr_next_s;
  logic [WIDTH-1:0] gnt_data_s;

  // The output register can take a new word when it is empty or being drained.
  assign load_en_s = !out_valid_r || out_ready;

  // Fixed-mode grant: compare select against each real channel index, so an
  // out-of-range select matches nothing instead of aliasing onto a channel.
  always_comb begin
    fix_hit_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (select == SELW'(i)) begin
        fix_hit_s = in_valid[i];
      end else begin
        fix_hit_s = fix_hit_s;
      end
    end
  end

  // Round-robin grant: lowest valid channel at or above rr_ptr wins; if none,
  // fall back to the lowest valid channel below rr_ptr (the wrapped part).
  always_comb begin
    hi_hit_s = 1'b0;
    hi_gnt_s = {SELW{1'b0}};
    lo_hit_s = 1'b0;
    lo_gnt_s = {SELW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i] && (SELW'(i) >= rr_ptr_r)) begin
        hi_hit_s = 1'b1;
        hi_gnt_s = SELW'(i);
      end else if (in_valid[i]) begin
        lo_hit_s = 1'b1;
        lo_gnt_s = SELW'(i);
      end else begin
        hi_hit_s = hi_hit_s;
      end
    end
  end

  // Final grant according to the current mode.
  always_comb begin
    gnt_hit_s = 1'b0;
    gnt_s     = {SELW{1'b0}};
    if (mode) begin
      gnt_hit_s = hi_hit_s || lo_hit_s;
      gnt_s     = hi_hit_s ? hi_gnt_s : lo_gnt_s;
    end else begin
      gnt_hit_s = fix_hit_s;
      gnt_s     = select;
    end
  end

  // One-hot consume strobe and word mux for the granted channel; reset
  // forces the strobe low so no producer sees a transfer that gets dropped.
  always_comb begin
    in_ready   = {N{1'b0}};
    gnt_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (gnt_s == SELW'(i)) begin
        in_ready[i] = load_en_s && gnt_hit_s && !reset;
        gnt_data_s  = in_data[i*WIDTH +: WIDTH];
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Pointer to the channel just after the winner, wrapping at N-1.
  assign rr_next_s = (gnt_s == SELW'(N - 1)) ? {SELW{1'b0}} : (gnt_s + {{(SELW-1){1'b0}}, 1'b1});

  // Output register and round-robin pointer; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= {SELW{1'b0}};
      out_valid_r <= 1'b0;
      rr_ptr_r    <= {SELW{1'b0}};
    end else if (load_en_s && gnt_hit_s) begin
      out_data_r  <= gnt_data_s;
      out_sel_r   <= gnt_s;
      out_valid_r <= 1'b1;
      rr_ptr_r    <= mode ? rr_next_s : rr_ptr_r;
    end else if (load_en_s) begin
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
      out_valid_r <= 1'b0;
      rr_ptr_r    <= rr_ptr_r;
    end else begin
      out_data_r  <= out_data_r;
      out_sel_r   <= out_sel_r;
      out_valid_r <= out_valid_r;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed bench for mux_arb_n, one 4-channel and one
// 3-channel instance sharing clock and reset.
module tb_mux_arb_n;

  logic        clk = 1'b0;
  logic        reset;

  logic [23:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  select;
  logic [5:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic [17:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  select3;
  logic [5:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        out_ready3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(6), .N(4), .SELW(2)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .select(select), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb_n #(.WIDTH(6), .N(3), .SELW(2)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(mode3), .select(select3), .out_data(out_data3),
    .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (out_data !== 6'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      vectors++; if (out_sel !== 2'd0) begin miscompares++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
      vectors++; if (out_valid3 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid3: got %b want 0", out_valid3); end
    end
    reset = 1'b0;
  endtask

  task automatic test_fixed();
    mode = 1'b0; select = 2'd2; in_valid = 4'b0101; out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL fixed_in_ready: got %b want 0100", in_ready); end
    tick();
    vectors++; if (out_data !== 6'h2A) begin miscompares++; $display("FAIL fixed_out_data: got %h want 2a", out_data); end
    vectors++; if (out_sel !== 2'd2) begin miscompares++; $display("FAIL fixed_out_sel: got %0d want 2", out_sel); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fixed_out_valid: got %b want 1", out_valid); end
    select = 2'd1;
    #1;
    vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL fixed_invalid_in_ready: got %b want 0000", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fixed_drop_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 6'h2A) begin miscompares++; $display("FAIL fixed_hold_data: got %h want 2a", out_data); end
    vectors++; if (out_sel !== 2'd2) begin miscompares++; $display("FAIL fixed_hold_sel: got %0d want 2", out_sel); end
  endtask

  task automatic test_rr();
    logic [1:0] exp_seq [9];
    logic [5:0] exp_dat [4];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0};
    exp_dat = '{6'h10, 6'h11, 6'h2A, 6'h33};
    mode = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 5) ? 4'b1111 : 4'b1001;
      #1;
      vectors++; if (in_ready !== (4'b0001 << exp_seq[k])) begin miscompares++; $display("FAIL rr_in_ready[%0d]: got %b want %b", k, in_ready, 4'b0001 << exp_seq[k]); end
      tick();
      vectors++; if (out_sel !== exp_seq[k]) begin miscompares++; $display("FAIL rr_out_sel[%0d]: got %0d want %0d", k, out_sel, exp_seq[k]); end
      vectors++; if (out_data !== exp_dat[exp_seq[k]]) begin miscompares++; $display("FAIL rr_out_data[%0d]: got %h want %h", k, out_data, exp_dat[exp_seq[k]]); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rr_out_valid[%0d]: got %b want 1", k, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    in_data[11:6] = 6'h15;
    mode = 1'b0; select = 2'd1; in_valid = 4'b0010; out_ready = 1'b1;
    tick();
    vectors++; if (out_data !== 6'h15) begin miscompares++; $display("FAIL bp_load_data: got %h want 15", out_data); end
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, in_ready); end
      tick();
      vectors++; if (out_data !== 6'h15) begin miscompares++; $display("FAIL bp_hold_data[%0d]: got %h want 15", c, out_data); end
      vectors++; if (out_sel !== 2'd1) begin miscompares++; $display("FAIL bp_hold_sel[%0d]: got %0d want 1", c, out_sel); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", c, out_valid); end
    end
    out_ready = 1'b1; select = 2'd3;
    #1;
    vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_refill_in_ready: got %b want 1000", in_ready); end
    tick();
    vectors++; if (out_data !== 6'h33) begin miscompares++; $display("FAIL bp_refill_data: got %h want 33", out_data); end
    vectors++; if (out_sel !== 2'd3) begin miscompares++; $display("FAIL bp_refill_sel: got %0d want 3", out_sel); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_refill_valid: got %b want 1", out_valid); end
    in_data[11:6] = 6'h11;
  endtask

  task automatic test_reset_mid();
    // rr pointer sits at 1 here, so a grant at 0 afterwards proves the reset.
    mode = 1'b1; out_ready = 1'b0; in_valid = 4'b1111;
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    reset = 1'b1;
    #1;
    vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_reset_in_ready: got %b want 0000", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_data !== 6'h00) begin miscompares++; $display("FAIL mid_reset_data: got %h want 00", out_data); end
    reset = 1'b0; out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_first_in_ready: got %b want 0001", in_ready); end
    tick();
    vectors++; if (out_sel !== 2'd0) begin miscompares++; $display("FAIL mid_first_sel: got %0d want 0", out_sel); end
    vectors++; if (out_data !== 6'h10) begin miscompares++; $display("FAIL mid_first_data: got %h want 10", out_data); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [4];
    logic [5:0] exp_dat [3];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_dat = '{6'h01, 6'h02, 6'h03};
    mode3 = 1'b0; select3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    vectors++; if (in_ready3 !== 3'b000) begin miscompares++; $display("FAIL wrap_oor_in_ready: got %b want 000", in_ready3); end
    tick();
    vectors++; if (out_valid3 !== 1'b0) begin miscompares++; $display("FAIL wrap_oor_valid: got %b want 0", out_valid3); end
    mode3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (in_ready3 !== (3'b001 << exp_seq[k])) begin miscompares++; $display("FAIL wrap_in_ready[%0d]: got %b want %b", k, in_ready3, 3'b001 << exp_seq[k]); end
      tick();
      vectors++; if (out_sel3 !== exp_seq[k]) begin miscompares++; $display("FAIL wrap_out_sel[%0d]: got %0d want %0d", k, out_sel3, exp_seq[k]); end
      vectors++; if (out_data3 !== exp_dat[exp_seq[k]]) begin miscompares++; $display("FAIL wrap_out_data[%0d]: got %h want %h", k, out_data3, exp_dat[exp_seq[k]]); end
    end
    mode3 = 1'b0; select3 = 2'd3;
    #1;
    vectors++; if (in_ready3 !== 3'b000) begin miscompares++; $display("FAIL wrap_oor2_in_ready: got %b want 000", in_ready3); end
    tick();
    vectors++; if (out_valid3 !== 1'b0) begin miscompares++; $display("FAIL wrap_oor2_valid: got %b want 0", out_valid3); end
    vectors++; if (out_sel3 !== 2'd0) begin miscompares++; $display("FAIL wrap_oor2_hold_sel: got %0d want 0", out_sel3); end
  endtask

  initial begin
    reset = 1'b1;
    in_data = {6'h33, 6'h2A, 6'h11, 6'h10};
    in_valid = 4'b0000; mode = 1'b0; select = 2'd0; out_ready = 1'b0;
    in_data3 = {6'h03, 6'h02, 6'h01};
    in_valid3 = 3'b000; mode3 = 1'b0; select3 = 2'd0; out_ready3 = 1'b1;
    #1;
    test_reset();
    test_fixed();
    test_rr();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-input, WIDTH-bit registered selector with valid/ready handshaking, the next generation of the team's fixed 6-bit 2-to-1 datapath muxes (e.g. MuxC). It picks one of N source channels, either by an explicit select (fixed mode) or by round-robin arbitration among valid sources. It registers the chosen word, with backpressure, for the downstream pipeline stage. It is intended for shared write-back and operand paths where several producers contend for one consumer.

## Interface
- WIDTH, 6, data width per channel (>=1)
- N, 4, number of input channels (>=2)
- SELW, 2, select/index width; must satisfy 2^SELW >= N

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i offers a word
- in_ready  output  N  channel i's word is consumed this cycle
- mode  input  1  0 = fixed select, 1 = round-robin
- select  input  SELW  channel index used in fixed mode
- out_data  output  WIDTH  registered selected word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream accepts out_data this cycle

## Operation
- Load enable: `load_en = !out_valid || out_ready`.
- Grant selection is combinational from the current inputs:
  - Fixed mode (mode=0): grant = select, but only if select < N and in_valid[select]. Otherwise there is no grant. Other channels are never granted, even if valid.
  - Round-robin mode (mode=1): grant = the first i with in_valid[i], searching rr_ptr, rr_ptr+1, …, N-1, 0, …, rr_ptr-1.
  - No valid channel means no grant.
- in_ready[i] = load_en && grant valid && grant == i. At most one bit of in_ready is set. in_ready is all zeros while reset is high.
- On a clock edge with load_en and a grant:
  - out_data <= word of the granted channel.
  - out_sel <= grant.
  - out_valid <= 1.
  - If mode=1, rr_ptr <= (grant == N-1) ? 0 : grant+1.
- On a clock edge with load_en and no grant: out_valid <= 0. out_data and out_sel hold their values.
- When out_valid=1 and out_ready=0: all registers hold and in_ready=0.
- rr_ptr holds when mode=0. A mode change takes effect in the same cycle, and rr_ptr is preserved across mode changes.
- Out-of-range select (select >= N) in fixed mode means no grant. It never produces X and never aliases to another channel.
- Internal state is the out_data, out_sel, out_valid and rr_ptr registers; there is no other storage.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr_ptr=0. Reset overrides any simultaneous transfer, and a word in flight is dropped.

## Timing
- Latency: 1 cycle from the in_valid/in_ready transfer edge to out_valid=1 with that data.
- Throughput: one word per cycle when out_ready stays high; no bubbles between back-to-back transfers.
- Simultaneous consume and refill: out_valid=1, out_ready=1 and a grant in the same cycle cause the register to reload with the new word and out_valid to stay 1.
- Combinational paths:
  - out_ready -> in_ready.
  - in_valid/select/mode -> in_ready.
  - No combinational path from any input to out_data, out_sel or out_valid.
- First cycle after reset deasserts: a transfer may occur; round-robin search starts at channel 0.

## Test plan
- **Reset:** hold reset 2 cycles with in_valid=4'b1111 and out_ready=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
- **Fixed mode:** mode=0, select=2, in_valid=4'b0101, channel 2 data=6'h2A, out_ready=1 -> in_ready=4'b0100; next cycle out_data=6'h2A, out_sel=2, out_valid=1. Then select=1 with in_valid[1]=0 -> in_ready=0 and out_valid drops to 0.
- **Round-robin fairness:** mode=1, in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles. Then in_valid=4'b1001 -> grants alternate 3,0,3,0.
- **Backpressure:** out_valid=1 with out_data=6'h15, out_ready=0 for 3 cycles while channels are valid -> in_ready=0, and out_data/out_sel stay stable. Raise out_ready -> the next word loads in the same cycle with no bubble.
- **Wrap/out-of-range:** N=3, SELW=2, mode=0, select=3 with in_valid=3'b111 -> no grant, out_valid=0. In mode=1 with the last grant at 2 -> rr_ptr wraps, and the next grant is 0.
- **Reset mid-operation:** out_valid=1 and out_ready=0, then assert reset for 1 cycle -> out_valid=0, out_data=0, and the next round-robin grant starts at channel 0.
